// File: rtl/freelist_alloc_ctrl.sv
// freelist_alloc_ctrl
// Sequencing controller for the two-in/two-out physical-register freelist
// FIFO in the rename stage.
//   - Grants rename-group allocations all-or-nothing and compacts sparse
//     requests onto the FIFO's first read port (zero-latency read data).
//   - Routes commit-time frees onto the FIFO write ports and committed
//     allocations onto the architectural read-pointer advance strobes.
//   - Runs exception recovery: one fl_excep_rst_o pulse, then an
//     allocation blackout of RECOVER_CYCLES cycles.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   ren_valid_i/ren_need_i       rename slot valid / needs a preg, [0]=older
//   ren_ready_o                  rename group accepted this cycle
//   ren_preg_first/second_o      preg handed to slot 0 / slot 1
//   ren_preg_valid_o             per-slot preg valid
//   fl_rd_first/second_en_o      freelist speculative read enables
//   fl_rdata_first/second_i      freelist read data (combinational)
//   fl_num_i                     freelist occupancy
//   cmt_valid/free/alloc_i       commit slot valid / frees old preg / had allocated
//   cmt_old_preg_i               old pregs, slot 0 in the low bits
//   cmt_ready_o                  commit accepted this cycle
//   fl_wr_first/second_en_o      freelist write enables
//   fl_wdata_first/second_o      freelist write data
//   fl_rd_excep_first/second_en_o architectural read-pointer advances
//   flush_i                      pipeline flush request (pulse)
//   fl_excep_rst_o               speculative pointer restore (registered)
//   state_o                      RUN=0, FLUSH=1, RECOVER=2
//   stall_cnt_o                  saturating count of rename stall cycles
//
// state   | meaning
// RUN     | normal allocation; commits accepted
// FLUSH   | excep_rst pulse to the freelist; rename and commit held off
// RECOVER | allocation blackout while the restored pointers settle
module freelist_alloc_ctrl #(
  parameter int PREG_WIDTH      = 5,
  parameter int FL_CNT_WIDTH    = 5,
  parameter int RECOVER_CYCLES  = 1,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 ren_valid_i,
  input  logic [1:0]                 ren_need_i,
  output logic                       ren_ready_o,
  output logic [PREG_WIDTH-1:0]      ren_preg_first_o,
  output logic [PREG_WIDTH-1:0]      ren_preg_second_o,
  output logic [1:0]                 ren_preg_valid_o,
  output logic                       fl_rd_first_en_o,
  output logic                       fl_rd_second_en_o,
  input  logic [PREG_WIDTH-1:0]      fl_rdata_first_i,
  input  logic [PREG_WIDTH-1:0]      fl_rdata_second_i,
  input  logic [FL_CNT_WIDTH:0]      fl_num_i,
  input  logic [1:0]                 cmt_valid_i,
  input  logic [1:0]                 cmt_free_i,
  input  logic [1:0]                 cmt_alloc_i,
  input  logic [2*PREG_WIDTH-1:0]    cmt_old_preg_i,
  output logic                       cmt_ready_o,
  output logic                       fl_wr_first_en_o,
  output logic                       fl_wr_second_en_o,
  output logic [PREG_WIDTH-1:0]      fl_wdata_first_o,
  output logic [PREG_WIDTH-1:0]      fl_wdata_second_o,
  output logic                       fl_rd_excep_first_en_o,
  output logic                       fl_rd_excep_second_en_o,
  input  logic                       flush_i,
  output logic                       fl_excep_rst_o,
  output logic [1:0]                 state_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

  localparam int FNW = FL_CNT_WIDTH + 1;
  localparam int CW  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [CW-1:0] REC_LOAD = CW'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              rec_cnt, rec_cnt_nxt;
  logic                       excep_rst_q;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt;

  logic [1:0] need, free_v, adv_v;
  logic       need_any, need_two, fl_ok, ren_ok, stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      rec_cnt     <= '0;
      excep_rst_q <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      rec_cnt     <= rec_cnt_nxt;
      excep_rst_q <= (state_nxt == ST_FLUSH);
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    rec_cnt_nxt = rec_cnt;
    case (state)
      ST_RUN: begin
        if (flush_i) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        // a repeated flush re-enters FLUSH and yields another pulse
        if (!flush_i) begin
          state_nxt   = ST_RECOVER;
          rec_cnt_nxt = REC_LOAD;
        end
      end
      ST_RECOVER: begin
        if (flush_i)
          state_nxt = ST_FLUSH;
        else if (rec_cnt == '0)
          state_nxt = ST_RUN;
        else
          rec_cnt_nxt = rec_cnt - CW'(1);
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    need     = ren_valid_i & ren_need_i;
    need_any = |need;
    need_two = &need;
    // all-or-nothing: the freelist must hold every preg the group needs
    fl_ok    = need_two ? (fl_num_i > FNW'(1)) : (!need_any || (fl_num_i != '0));
    ren_ok   = (state == ST_RUN) && !flush_i && fl_ok;
    stall    = (state == ST_RUN) && (ren_valid_i != 2'b00) && !ren_ok;

    ren_ready_o       = 1'b0;
    ren_preg_first_o  = '0;
    ren_preg_second_o = '0;
    ren_preg_valid_o  = 2'b00;
    fl_rd_first_en_o  = 1'b0;
    fl_rd_second_en_o = 1'b0;
    cmt_ready_o       = 1'b0;
    free_v            = 2'b00;
    adv_v             = 2'b00;

    if (!rst) begin
      ren_ready_o      = ren_ok;
      ren_preg_valid_o = need & {2{ren_ok}};
      if (ren_ok && (ren_valid_i != 2'b00)) begin
        fl_rd_first_en_o  = need_any;
        fl_rd_second_en_o = need_two;
      end
      if (ren_ok) begin
        // a lone request always takes the first read port
        if (need[0]) ren_preg_first_o = fl_rdata_first_i;
        if (need_two)
          ren_preg_second_o = fl_rdata_second_i;
        else if (need[1])
          ren_preg_second_o = fl_rdata_first_i;
      end
      cmt_ready_o = (state != ST_FLUSH);
      free_v      = cmt_valid_i & cmt_free_i;
      adv_v       = cmt_valid_i & cmt_alloc_i & {2{cmt_ready_o}};
    end

    // commit-side traffic is compacted onto the first port
    fl_wr_first_en_o        = |free_v;
    fl_wr_second_en_o       = &free_v;
    fl_wdata_first_o        = free_v[0] ? cmt_old_preg_i[PREG_WIDTH-1:0] :
                              free_v[1] ? cmt_old_preg_i[2*PREG_WIDTH-1:PREG_WIDTH] : '0;
    fl_wdata_second_o       = (&free_v) ? cmt_old_preg_i[2*PREG_WIDTH-1:PREG_WIDTH] : '0;
    fl_rd_excep_first_en_o  = |adv_v;
    fl_rd_excep_second_en_o = &adv_v;
  end

  assign fl_excep_rst_o = excep_rst_q;
  assign state_o        = state;
  assign stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_freelist_alloc_ctrl.sv
// Scoreboard bench for freelist_alloc_ctrl: the driver applies one cycle of
// inputs, derives the expected outputs from a behavioural model and queues
// them; the monitor pops and compares on the falling edge.
module tb_freelist_alloc_ctrl;
  localparam int PW = 5;
  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ren_valid_i = '0, ren_need_i = '0;
  logic        ren_ready_o;
  logic [PW-1:0] ren_preg_first_o, ren_preg_second_o;
  logic [1:0]  ren_preg_valid_o;
  logic        fl_rd_first_en_o, fl_rd_second_en_o;
  logic [PW-1:0] fl_rdata_first_i = '0, fl_rdata_second_i = '0;
  logic [5:0]  fl_num_i = '0;
  logic [1:0]  cmt_valid_i = '0, cmt_free_i = '0, cmt_alloc_i = '0;
  logic [2*PW-1:0] cmt_old_preg_i = '0;
  logic        cmt_ready_o;
  logic        fl_wr_first_en_o, fl_wr_second_en_o;
  logic [PW-1:0] fl_wdata_first_o, fl_wdata_second_o;
  logic        fl_rd_excep_first_en_o, fl_rd_excep_second_en_o;
  logic        flush_i = 1'b0;
  logic        fl_excep_rst_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;

  always #5 clk = ~clk;

  freelist_alloc_ctrl #(.PREG_WIDTH(PW), .FL_CNT_WIDTH(5), .RECOVER_CYCLES(RC),
                        .STALL_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .ren_valid_i(ren_valid_i), .ren_need_i(ren_need_i), .ren_ready_o(ren_ready_o),
    .ren_preg_first_o(ren_preg_first_o), .ren_preg_second_o(ren_preg_second_o),
    .ren_preg_valid_o(ren_preg_valid_o),
    .fl_rd_first_en_o(fl_rd_first_en_o), .fl_rd_second_en_o(fl_rd_second_en_o),
    .fl_rdata_first_i(fl_rdata_first_i), .fl_rdata_second_i(fl_rdata_second_i),
    .fl_num_i(fl_num_i),
    .cmt_valid_i(cmt_valid_i), .cmt_free_i(cmt_free_i), .cmt_alloc_i(cmt_alloc_i),
    .cmt_old_preg_i(cmt_old_preg_i), .cmt_ready_o(cmt_ready_o),
    .fl_wr_first_en_o(fl_wr_first_en_o), .fl_wr_second_en_o(fl_wr_second_en_o),
    .fl_wdata_first_o(fl_wdata_first_o), .fl_wdata_second_o(fl_wdata_second_o),
    .fl_rd_excep_first_en_o(fl_rd_excep_first_en_o),
    .fl_rd_excep_second_en_o(fl_rd_excep_second_en_o),
    .flush_i(flush_i), .fl_excep_rst_o(fl_excep_rst_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic          ren_ready;
    logic [PW-1:0] p0, p1;
    logic [1:0]    pv;
    logic          rd0, rd1, wr0, wr1;
    logic [PW-1:0] wd0, wd1;
    logic          ex0, ex1, cmt_ready, excep_rst;
    logic [1:0]    state;
    logic [15:0]   stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // model: mode 0=RUN 1=FLUSH 2=RECOVER, left = blackout cycles still owed
  int mode    = 0;
  int left    = 0;
  int stall_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ren_ready",   32'(ren_ready_o),             32'(e.ren_ready));
      chk("preg_first",  32'(ren_preg_first_o),        32'(e.p0));
      chk("preg_second", 32'(ren_preg_second_o),       32'(e.p1));
      chk("preg_valid",  32'(ren_preg_valid_o),        32'(e.pv));
      chk("rd_first",    32'(fl_rd_first_en_o),        32'(e.rd0));
      chk("rd_second",   32'(fl_rd_second_en_o),       32'(e.rd1));
      chk("wr_first",    32'(fl_wr_first_en_o),        32'(e.wr0));
      chk("wr_second",   32'(fl_wr_second_en_o),       32'(e.wr1));
      chk("wdata_first", 32'(fl_wdata_first_o),        32'(e.wd0));
      chk("wdata_second",32'(fl_wdata_second_o),       32'(e.wd1));
      chk("excep_first", 32'(fl_rd_excep_first_en_o),  32'(e.ex0));
      chk("excep_second",32'(fl_rd_excep_second_en_o), 32'(e.ex1));
      chk("cmt_ready",   32'(cmt_ready_o),             32'(e.cmt_ready));
      chk("excep_rst",   32'(fl_excep_rst_o),          32'(e.excep_rst));
      chk("state",       32'(state_o),                 32'(e.state));
      chk("stall_cnt",   32'(stall_cnt_o),             32'(e.stall));
    end
  end

  task automatic step(input logic r, input logic [1:0] v, input logic [1:0] nd,
                      input logic [PW-1:0] d0, input logic [PW-1:0] d1,
                      input logic [5:0] num, input logic [1:0] cv, input logic [1:0] cf,
                      input logic [1:0] ca, input logic [2*PW-1:0] old, input logic fl);
    exp_t          e;
    logic [1:0]    need;
    logic [PW-1:0] src[2];
    logic [PW-1:0] frees[$];
    int            n, k, m;
    logic          ready;
    @(posedge clk);
    #1;
    rst = r; ren_valid_i = v; ren_need_i = nd; fl_rdata_first_i = d0;
    fl_rdata_second_i = d1; fl_num_i = num; cmt_valid_i = cv; cmt_free_i = cf;
    cmt_alloc_i = ca; cmt_old_preg_i = old; flush_i = fl;

    e.state     = 2'(mode);
    e.excep_rst = (mode == 1);
    e.stall     = 16'(stall_m);

    need  = v & nd;
    n     = $countones(need);
    ready = !r && (mode == 0) && !fl && (int'(num) >= n);
    e.ren_ready = ready;
    src[0] = d0; src[1] = d1;
    e.p0 = '0; e.p1 = '0; e.pv = 2'b00;
    k = 0;
    for (int i = 0; i < 2; i++) begin
      if (need[i] && ready) begin
        if (i == 0) e.p0 = src[k]; else e.p1 = src[k];
        e.pv[i] = 1'b1;
        k++;
      end
    end
    e.rd0 = ready && (v != 2'b00) && (n >= 1);
    e.rd1 = ready && (v != 2'b00) && (n == 2);

    if (!r)
      for (int i = 0; i < 2; i++)
        if (cv[i] && cf[i]) frees.push_back(old[i*PW +: PW]);
    e.wr0 = frees.size() > 0;
    e.wr1 = frees.size() > 1;
    e.wd0 = (frees.size() > 0) ? frees[0] : '0;
    e.wd1 = (frees.size() > 1) ? frees[1] : '0;

    e.cmt_ready = !r && (mode != 1);
    m = 0;
    for (int i = 0; i < 2; i++)
      if (cv[i] && ca[i] && e.cmt_ready) m++;
    e.ex0 = (m >= 1);
    e.ex1 = (m == 2);
    exp_q.push_back(e);

    if (r) begin
      mode = 0; left = 0; stall_m = 0;
    end else begin
      if ((mode == 0) && (v != 2'b00) && !ready && (stall_m < 65535)) stall_m++;
      case (mode)
        0: if (fl) mode = 1;
        1: if (!fl) begin mode = 2; left = RC; end
        default: begin
          if (fl) mode = 1;
          else begin
            left--;
            if (left == 0) mode = 0;
          end
        end
      endcase
    end
  endtask

  task automatic idle(input logic r);
    step(r, 2'b00, 2'b00, '0, '0, 6'd4, 2'b00, 2'b00, 2'b00, '0, 1'b0);
  endtask

  initial begin
    // reset with live inputs: every combinational output must stay low
    step(1, 2'b11, 2'b11, 5'd1, 5'd2, 6'd5, 2'b11, 2'b11, 2'b11, 10'h3ff, 1'b0);
    idle(1);
    step(0, 2'b11, 2'b11, 5'd7,  5'd9, 6'd5, 2'b00, 2'b00, 2'b00, '0, 1'b0);
    step(0, 2'b11, 2'b10, 5'd12, 5'd4, 6'd5, 2'b00, 2'b00, 2'b00, '0, 1'b0);
    repeat (3) step(0, 2'b11, 2'b11, 5'd3, 5'd6, 6'd1, 2'b00, 2'b00, 2'b00, '0, 1'b0);
    step(0, 2'b00, 2'b00, '0, '0, 6'd1, 2'b11, 2'b10, 2'b01, {5'd20, 5'd3}, 1'b0);
    // flush with a commit in the same cycle, then watch the blackout
    step(0, 2'b11, 2'b11, 5'd1, 5'd2, 6'd8, 2'b11, 2'b11, 2'b11, {5'd8, 5'd4}, 1'b1);
    repeat (2) step(0, 2'b11, 2'b01, 5'd5, 5'd6, 6'd8, 2'b11, 2'b01, 2'b11, {5'd10, 5'd11}, 1'b0);
    repeat (3) step(0, 2'b01, 2'b01, 5'd5, 5'd6, 6'd8, 2'b00, 2'b00, 2'b00, '0, 1'b0);
    // back-to-back flushes
    step(0, 2'b00, 2'b00, '0, '0, 6'd8, 2'b00, 2'b00, 2'b00, '0, 1'b1);
    step(0, 2'b00, 2'b00, '0, '0, 6'd8, 2'b00, 2'b00, 2'b00, '0, 1'b1);
    repeat (4) idle(0);

    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(199) == 0),
           2'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
           6'($urandom_range(3)), 2'($urandom), 2'($urandom), 2'($urandom),
           10'($urandom), ($urandom_range(15) == 0));
    end

    // drive the stall counter into saturation
    idle(1);
    for (int c = 0; c < 65540; c++)
      step(0, 2'b11, 2'b11, 5'd1, 5'd2, 6'd0, 2'b00, 2'b00, 2'b00, '0, 1'b0);
    idle(0);
    // reset in the middle of recovery
    step(0, 2'b00, 2'b00, '0, '0, 6'd4, 2'b00, 2'b00, 2'b00, '0, 1'b1);
    idle(0);
    idle(0);
    idle(1);
    idle(0);
    step(0, 2'b11, 2'b11, 5'd13, 5'd14, 6'd2, 2'b00, 2'b00, 2'b00, '0, 1'b0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/freelist_alloc_ctrl.md
Name: freelist_alloc_ctrl

Overview:
Sequencing controller for the two-in/two-out physical-register freelist FIFO in the rename stage.
- Grants rename-group allocations all-or-nothing, and compacts sparse requests onto the FIFO's first port.
- Routes commit-time frees and architectural-pointer advances into the FIFO.
- Runs the exception-recovery sequence (excep_rst pulse, then allocation blackout).

Parameters:
PREG_WIDTH, 5, physical register index width (matches freelist data width)
FL_CNT_WIDTH, 5, freelist count width; fl_num_i is FL_CNT_WIDTH+1 bits
RECOVER_CYCLES, 1, allocation blackout cycles after excep_rst pulse (>=1)
STALL_CNT_WIDTH, 16, width of saturating stall counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ren_valid_i  in  2  rename slot valid, [0]=older
ren_need_i  in  2  slot needs a new preg (rd != x0)
ren_ready_o  out  1  rename group accepted this cycle
ren_preg_first_o  out  PREG_WIDTH  preg for slot 0
ren_preg_second_o  out  PREG_WIDTH  preg for slot 1
ren_preg_valid_o  out  2  per-slot preg valid
fl_rd_first_en_o / fl_rd_second_en_o  out  1 each  freelist speculative read enables
fl_rdata_first_i / fl_rdata_second_i  in  PREG_WIDTH each  freelist read data (combinational)
fl_num_i  in  FL_CNT_WIDTH+1  freelist occupancy
cmt_valid_i  in  2  commit slot valid
cmt_free_i  in  2  commit slot releases an old preg
cmt_alloc_i  in  2  committed instr had allocated a preg
cmt_old_preg_i  in  2*PREG_WIDTH  old pregs, slot0 in low bits
cmt_ready_o  out  1  commit accepted this cycle
fl_wr_first_en_o / fl_wr_second_en_o  out  1 each  freelist write enables
fl_wdata_first_o / fl_wdata_second_o  out  PREG_WIDTH each  freelist write data
fl_rd_excep_first_en_o / fl_rd_excep_second_en_o  out  1 each  architectural read-pointer advances
flush_i  in  1  pipeline flush request (pulse)
fl_excep_rst_o  out  1  freelist speculative pointer restore
state_o  out  2  RUN=0, FLUSH=1, RECOVER=2
stall_cnt_o  out  STALL_CNT_WIDTH  saturating count of rename stall cycles

Behaviour:
- Reset: state=RUN, recover counter=0, stall_cnt_o=0, fl_excep_rst_o=0. All combinational outputs are 0 while rst=1.
- Allocation:
  - need = valid & need bits; n = popcount(need).
  - ren_ready_o = (state==RUN) & !flush_i & (fl_num_i >= n).
  - Read enables are asserted only when ren_ready_o=1 and any ren_valid_i bit is set. n=1 asserts fl_rd_first_en_o only; n=2 asserts both.
  - Mapping: n=2 -> slot0 gets first, slot1 gets second. n=1 -> the needing slot gets fl_rdata_first_i.
  - Zero-latency: pregs are valid in the same cycle as ren_ready_o. ren_preg_valid_o = need & {2{ren_ready_o}}. Unused preg outputs = 0.
  - Partial grant never occurs. If fl_num_i=1 and n=2: no read, ren_ready_o=0.
- Commit frees:
  - f = cmt_valid_i & cmt_free_i, compacted to the first port. f=01 or 10 -> wr_first only, with that slot's preg. f=11 -> both, slot0 on first.
  - Frees are accepted in every state; writes are never gated.
- Commit arch advance:
  - a = cmt_valid_i & cmt_alloc_i, compacted the same way onto rd_excep_first/second.
  - Gated by cmt_ready_o; rd_excep enables are 0 when cmt_ready_o=0.
  - cmt_ready_o = (state != FLUSH).
- FSM:
  - RUN: flush_i -> FLUSH. Commit in the flush_i cycle is still accepted.
  - FLUSH: fl_excep_rst_o=1 (registered, exactly one cycle); cmt_ready_o=0; ren_ready_o=0. Next state is RECOVER and the counter is loaded with RECOVER_CYCLES-1.
  - RECOVER: ren_ready_o=0; counter decrements; at 0 -> RUN. flush_i here -> FLUSH again.
  - flush_i in FLUSH re-enters FLUSH, giving a second excep_rst pulse.
- stall_cnt_o: increments in cycles where state==RUN, ren_valid_i != 0 and ren_ready_o=0. Saturates at all-ones. Cleared only by rst.
- Mid-operation reset forces RUN on the next edge; no excep_rst pulse is issued.

Test Plan:
- fl_num_i=5, ren_valid=11, need=11, rdata 7/9 -> ren_ready=1, rd_first/second=1, slot pregs 7/9, valid=11.
- need=10, rdata_first=12 -> only fl_rd_first_en=1, ren_preg_second_o=12, ren_preg_valid=10.
- fl_num_i=1, need=11 for 3 cycles -> ren_ready=0, no read enables, stall_cnt_o=3.
- cmt_valid=11, free=10, alloc=01, old pregs {slot1=20, slot0=3} -> wr_first=1 with data 20, wr_second=0, rd_excep_first=1.
- flush_i pulse in RUN with RECOVER_CYCLES=2 -> next cycle fl_excep_rst_o=1 and cmt_ready_o=0, then 2 RECOVER cycles with ren_ready=0, then RUN.
- stall_cnt_o preset near saturation (16'hFFFE), 3 stall cycles -> holds at 16'hFFFF; rst mid-RECOVER -> state RUN, stall_cnt_o=0.
